deleted_node_cam: RTL and testbench

Parametrised content-addressable store of deleted node IDs for the gene-processing PE. It accepts insertions through a valid/ready handshake and suppresses duplicates. It supports removal of a single ID and a bulk clear. It answers NUM_QUERY parallel membership lookups with registered results, so the connection/node pipeline can drop genes that reference deleted nodes. It extends the earlier fixed two-lookup deleted-node list with per-entry valid bits, removal, occupancy reporting and overflow detection.

---
 rtl/deleted_node_cam.sv | 142 ++++++++++++++
 tb/tb_deleted_node_cam.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/deleted_node_cam.sv
// deleted_node_cam
//   Content-addressable store of deleted node IDs. Accepts inserts through a
//   valid/ready handshake and suppresses duplicates. Supports removal of one
//   ID and a bulk clear. Answers NUM_QUERY parallel membership lookups with
//   results registered one cycle later.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ins_valid/ins_id    insert request; ins_ready = !full
//   del_valid/del_id    remove request (absent ID is a no-op)
//   clr                 synchronous clear of all entries and ovf
//   q_id                lookup IDs, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   q_match, q_any      registered per-port hit and OR of all hits
//   count, full, empty  registered occupancy status
//   ovf                 sticky: non-duplicate insert attempted while full
module deleted_node_cam #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int NUM_QUERY  = 2,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ins_valid,
  input  logic [DATA_WIDTH-1:0]           ins_id,
  output logic                            ins_ready,
  input  logic                            del_valid,
  input  logic [DATA_WIDTH-1:0]           del_id,
  input  logic                            clr,
  input  logic [NUM_QUERY*DATA_WIDTH-1:0] q_id,
  output logic [NUM_QUERY-1:0]            q_match,
  output logic                            q_any,
  output logic [CW-1:0]                   count,
  output logic                            full,
  output logic                            empty,
  output logic                            ovf
);

  localparam int IW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_id [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_ovf;
  logic [NUM_QUERY-1:0]  r_q_match_p1;
  logic                  r_q_any_p1;

  logic [DEPTH-1:0]      w_ins_match;
  logic [DEPTH-1:0]      w_del_match;
  logic                  w_ins_hit;
  logic [IW-1:0]         w_free_idx;
  logic                  w_ins_do;
  logic [DEPTH-1:0]      w_vld_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic [NUM_QUERY-1:0]  w_q_hit;

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // ---- Stage 0: compare against contents registered at start of cycle ----
  always_comb begin
    w_ins_match = '0;
    w_del_match = '0;
    w_free_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ins_match[i] = r_vld[i] && (r_id[i] == ins_id);
      w_del_match[i] = r_vld[i] && (r_id[i] == del_id);
    end
    // Scan downward so the last assignment wins: lowest invalid slot.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_vld[i]) w_free_idx = IW'(i);
    end
    w_ins_hit = |w_ins_match;
    // Insert is dropped when it collides with a same-cycle delete of the
    // same ID; a free slot always exists when not full.
    w_ins_do = ins_valid && !r_full && !w_ins_hit && !clr &&
               !(del_valid && (del_id == ins_id));

    w_vld_nxt = r_vld;
    if (clr) begin
      w_vld_nxt = '0;
    end else begin
      if (del_valid) w_vld_nxt = w_vld_nxt & ~w_del_match;
      // Free slot chosen from pre-cycle bits, so a slot freed now is not reused.
      if (w_ins_do) w_vld_nxt[w_free_idx] = 1'b1;
    end
    w_count_nxt = popcount(w_vld_nxt);
  end

  always_comb begin
    w_q_hit = '0;
    for (int k = 0; k < NUM_QUERY; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && (r_id[i] == q_id[k*DATA_WIDTH +: DATA_WIDTH]))
          w_q_hit[k] = 1'b1;
      end
    end
  end

  // ---- Stage 1: registered contents, status and lookup results ----
  always_ff @(posedge clk) begin
    if (w_ins_do) r_id[w_free_idx] <= ins_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld        <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_ovf        <= 1'b0;
      r_q_match_p1 <= '0;
      r_q_any_p1   <= 1'b0;
    end else begin
      r_vld        <= w_vld_nxt;
      r_count      <= w_count_nxt;
      r_full       <= (w_count_nxt == CW'(DEPTH));
      r_empty      <= (w_count_nxt == '0);
      r_q_match_p1 <= w_q_hit;
      r_q_any_p1   <= |w_q_hit;
      if (clr)
        r_ovf <= 1'b0;
      else if (ins_valid && r_full && !w_ins_hit)
        r_ovf <= 1'b1;
    end
  end

  assign ins_ready = !r_full;
  assign q_match   = r_q_match_p1;
  assign q_any     = r_q_any_p1;
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_deleted_node_cam.sv
module tb_deleted_node_cam;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ins_valid = 1'b0;
  logic [7:0]  ins_id = '0;
  logic        ins_ready;
  logic        del_valid = 1'b0;
  logic [7:0]  del_id = '0;
  logic        clr = 1'b0;
  logic [15:0] q_id = '0;
  logic [1:0]  q_match;
  logic        q_any;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  deleted_node_cam dut (
    .clk(clk), .rst_n(rst_n),
    .ins_valid(ins_valid), .ins_id(ins_id), .ins_ready(ins_ready),
    .del_valid(del_valid), .del_id(del_id), .clr(clr),
    .q_id(q_id), .q_match(q_match), .q_any(q_any),
    .count(count), .full(full), .empty(empty), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [7:0] id);
    ins_valid = 1'b1; ins_id = id;
    step();
    ins_valid = 1'b0;
  endtask

  task automatic del(input logic [7:0] id);
    del_valid = 1'b1; del_id = id;
    step();
    del_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // a on port 0, b on port 1
  task automatic query(input logic [7:0] a, input logic [7:0] b);
    q_id = {b, a};
    step();
  endtask

  task automatic fill8();
    for (int i = 1; i <= 8; i++) ins(8'(i));
  endtask

  initial begin
    step();
    step();
    rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ready", 32'(ins_ready), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_qmatch", 32'(q_match), 32'd0);
    chk("rst_qany", 32'(q_any), 32'd0);

    // Basic insert and lookup
    ins(8'h11); ins(8'h22); ins(8'h33);
    query(8'h22, 8'h44);
    chk("basic_qmatch", 32'(q_match), 32'b01);
    chk("basic_qany", 32'(q_any), 32'd1);
    chk("basic_count", 32'(count), 32'd3);
    chk("basic_empty", 32'(empty), 32'd0);
    query(8'h55, 8'h66);
    chk("basic_miss_qany", 32'(q_any), 32'd0);

    // Fill, duplicate while full, overflow
    do_clr();
    fill8();
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(ins_ready), 32'd0);
    ins(8'h03);
    chk("dup_full_ovf", 32'(ovf), 32'd0);
    chk("dup_full_count", 32'(count), 32'd8);
    ins(8'h09);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    query(8'h09, 8'h08);
    chk("ovf_not_stored", 32'(q_match), 32'b10);

    // Delete and reuse of freed slot
    do_clr();
    chk("clr_ovf", 32'(ovf), 32'd0);
    fill8();
    del(8'h04);
    chk("del_count", 32'(count), 32'd7);
    chk("del_full", 32'(full), 32'd0);
    ins(8'hAA);
    chk("reuse_count", 32'(count), 32'd8);
    query(8'h04, 8'hAA);
    chk("reuse_qmatch", 32'(q_match), 32'b10);
    del(8'hEE);
    chk("del_absent_count", 32'(count), 32'd8);

    // Same-cycle insert and delete
    do_clr();
    ins(8'h11); ins(8'h22); ins(8'h55); ins(8'h77); ins(8'h88); ins(8'h99);
    chk("same_pre_count", 32'(count), 32'd6);
    ins_valid = 1'b1; ins_id = 8'h55; del_valid = 1'b1; del_id = 8'h55;
    step();
    ins_valid = 1'b0; del_valid = 1'b0;
    chk("same_id_count", 32'(count), 32'd5);
    query(8'h55, 8'h11);
    chk("same_id_absent", 32'(q_match), 32'b10);
    ins_valid = 1'b1; ins_id = 8'h66; del_valid = 1'b1; del_id = 8'h77;
    step();
    ins_valid = 1'b0; del_valid = 1'b0;
    chk("diff_id_count", 32'(count), 32'd5);
    query(8'h66, 8'h77);
    chk("diff_id_qmatch", 32'(q_match), 32'b01);

    // Clear beats a same-cycle insert
    do_clr();
    fill8();
    ins(8'h09);
    del(8'h07); del(8'h08);
    chk("pre_clr_count", 32'(count), 32'd6);
    chk("pre_clr_ovf", 32'(ovf), 32'd1);
    clr = 1'b1; ins_valid = 1'b1; ins_id = 8'h99;
    step();
    clr = 1'b0; ins_valid = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_ovf2", 32'(ovf), 32'd0);
    query(8'h99, 8'h01);
    chk("clr_no_99", 32'(q_match), 32'b00);

    // Asynchronous reset mid-cycle
    ins(8'hA1); ins(8'hA2); ins(8'hA3); ins(8'hA4);
    query(8'hA1, 8'hA2);
    chk("pre_arst_qmatch", 32'(q_match), 32'b11);
    chk("pre_arst_count", 32'(count), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_qmatch", 32'(q_match), 32'b00);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_ready", 32'(ins_ready), 32'd1);
    #2 rst_n = 1'b1;
    step();
    chk("post_arst_qmatch", 32'(q_match), 32'b00);
    query(8'hA3, 8'hA4);
    chk("post_arst_qany", 32'(q_any), 32'd0);
    chk("post_arst_count", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
